// File: rtl/alu_4_bit_wide_sequencer_if.sv
// Command and ALU-side bundle for the wide nibble sequencer.
// master: control path plus the 4-bit ALU it drives; slave: the sequencer.
// Abort_In exists only when ALU_SEQ_ABORT_EN is defined.
interface alu_4_bit_wide_sequencer_if #(
  parameter int NUM_NIBBLES = 4
);
  localparam int W = 4 * NUM_NIBBLES;

  // command side
  logic         Start_In;
  logic         Ready_Out;
  logic [W-1:0] Operand_A_In;
  logic [W-1:0] Operand_B_In;
  logic [3:0]   Operation_Select_In;
  logic         Carry_Borrowb_In;
  logic         Chain_Carry_In;
`ifdef ALU_SEQ_ABORT_EN
  logic         Abort_In;
`endif

  // ALU side
  logic         Alu_Reset_Out;
  logic [3:0]   Alu_Data_A_Out;
  logic [3:0]   Alu_Data_B_Out;
  logic         Alu_Carry_Borrowb_Out;
  logic [3:0]   Alu_Operation_Select_Out;
  logic [3:0]   Alu_Result_In;
  logic         Alu_Carry_In;

  // result side
  logic [W-1:0] Result_Out;
  logic         Carry_Out;
  logic         Done_Out;

  modport master (
    output Start_In, Operand_A_In, Operand_B_In, Operation_Select_In,
    output Carry_Borrowb_In, Chain_Carry_In,
`ifdef ALU_SEQ_ABORT_EN
    output Abort_In,
`endif
    output Alu_Result_In, Alu_Carry_In,
    input  Ready_Out, Alu_Reset_Out, Alu_Data_A_Out, Alu_Data_B_Out,
    input  Alu_Carry_Borrowb_Out, Alu_Operation_Select_Out,
    input  Result_Out, Carry_Out, Done_Out
  );

  modport slave (
    input  Start_In, Operand_A_In, Operand_B_In, Operation_Select_In,
    input  Carry_Borrowb_In, Chain_Carry_In,
`ifdef ALU_SEQ_ABORT_EN
    input  Abort_In,
`endif
    input  Alu_Result_In, Alu_Carry_In,
    output Ready_Out, Alu_Reset_Out, Alu_Data_A_Out, Alu_Data_B_Out,
    output Alu_Carry_Borrowb_Out, Alu_Operation_Select_Out,
    output Result_Out, Carry_Out, Done_Out
  );
endinterface

// File: rtl/alu_4_bit_wide_sequencer.sv
// Runs W-bit operands through one shared 4-bit ALU, one nibble per clock, LS nibble first.
// Latency: accept edge T, NUM_NIBBLES EXEC cycles, Done_Out pulses in cycle T+NUM_NIBBLES.
// Backpressure: Ready_Out low in EXEC/DONE; Start_In then ignored (no queueing). Option: ALU_SEQ_ABORT_EN.
module alu_4_bit_wide_sequencer #(
  parameter int NUM_NIBBLES = 4
) (
  input  logic                      Clock_In,
  input  logic                      Resetb_In,
  alu_4_bit_wide_sequencer_if.slave bus
);

  localparam int W     = 4 * NUM_NIBBLES;
  localparam int IDX_W = $clog2(NUM_NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q,     state_d;
  logic [IDX_W-1:0] idx_q,       idx_d;
  logic [W-1:0]     a_q,         a_d;
  logic [W-1:0]     b_q,         b_d;
  logic [3:0]       op_q,        op_d;
  logic             cin_q,       cin_d;
  logic             chain_q,     chain_d;
  logic             carry_q,     carry_d;
  logic [W-1:0]     acc_q,       acc_d;
  logic [W-1:0]     result_q,    result_d;
  logic             carry_out_q, carry_out_d;
  logic             ready_q,     ready_d;
  logic             done_q,      done_d;
  logic             alu_rst_q,   alu_rst_d;

  // bit offset of the current nibble inside the wide words
  logic [IDX_W+1:0] nib_lsb;
  assign nib_lsb = {idx_q, 2'b00};

  // drive the ALU from the latched command; quiet outside EXEC
  always_comb begin
    bus.Alu_Data_A_Out           = 4'h0;
    bus.Alu_Data_B_Out           = 4'h0;
    bus.Alu_Carry_Borrowb_Out    = 1'b0;
    bus.Alu_Operation_Select_Out = 4'h0;
    if (state_q == EXEC) begin
      bus.Alu_Data_A_Out           = a_q[nib_lsb +: 4];
      bus.Alu_Data_B_Out           = b_q[nib_lsb +: 4];
      bus.Alu_Operation_Select_Out = op_q;
      // nibble 0, or unchained mode, always takes the command's carry-in
      bus.Alu_Carry_Borrowb_Out    = (idx_q == '0 || !chain_q) ? cin_q : carry_q;
    end
  end

  // next-state and datapath update
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    cin_d       = cin_q;
    chain_d     = chain_q;
    carry_d     = carry_q;
    acc_d       = acc_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;

    case (state_q)
      IDLE: begin
        if (bus.Start_In && ready_q) begin
          a_d     = bus.Operand_A_In;
          b_d     = bus.Operand_B_In;
          op_d    = bus.Operation_Select_In;
          cin_d   = bus.Carry_Borrowb_In;
          chain_d = bus.Chain_Carry_In;
          idx_d   = '0;
          state_d = EXEC;
        end
      end

      EXEC: begin
        acc_d[nib_lsb +: 4] = bus.Alu_Result_In;
        carry_d             = bus.Alu_Carry_In;
`ifdef ALU_SEQ_ABORT_EN
        // abort wins over the final-nibble transition; published result untouched
        if (bus.Abort_In) begin
          idx_d   = '0;
          state_d = IDLE;
        end else
`endif
        if (idx_q == LAST_IDX) begin
          // publish the full word and last carry together on entry to DONE
          result_d    = acc_d;
          carry_out_d = bus.Alu_Carry_In;
          idx_d       = '0;
          state_d     = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase

    // handshake outputs are registered copies of the next state
    ready_d   = (state_d == IDLE);
    done_d    = (state_d == DONE);
    // ALU reset is held only until the first edge after reset release
    alu_rst_d = 1'b0;
  end

  // state register; asynchronous reset drops any command in flight
  always_ff @(posedge Clock_In or negedge Resetb_In) begin
    if (!Resetb_In) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 4'h0;
      cin_q       <= 1'b0;
      chain_q     <= 1'b0;
      carry_q     <= 1'b0;
      acc_q       <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      alu_rst_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      cin_q       <= cin_d;
      chain_q     <= chain_d;
      carry_q     <= carry_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      alu_rst_q   <= alu_rst_d;
    end
  end

  assign bus.Ready_Out     = ready_q;
  assign bus.Done_Out      = done_q;
  assign bus.Result_Out    = result_q;
  assign bus.Carry_Out     = carry_out_q;
  assign bus.Alu_Reset_Out = alu_rst_q;

endmodule

// File: tb/tb_alu_4_bit_wide_sequencer.sv
// Directed bench for alu_4_bit_wide_sequencer with NUM_NIBBLES = 4 and a behavioural add ALU.
// Expected {carry,result} pairs are queued at command issue and checked on each Done_Out.
module tb_alu_4_bit_wide_sequencer;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  logic [W:0] sb[$];

  alu_4_bit_wide_sequencer_if #(.NUM_NIBBLES(N)) bus ();

  alu_4_bit_wide_sequencer #(.NUM_NIBBLES(N)) dut (
    .Clock_In  (clk),
    .Resetb_In (rst_n),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model: opcode 1 adds A+B+Cin, anything else yields zero
  always_comb begin
    if (bus.Alu_Operation_Select_Out == 4'h1)
      {bus.Alu_Carry_In, bus.Alu_Result_In} =
        {1'b0, bus.Alu_Data_A_Out} + {1'b0, bus.Alu_Data_B_Out} + {4'h0, bus.Alu_Carry_Borrowb_Out};
    else
      {bus.Alu_Carry_In, bus.Alu_Result_In} = 5'h00;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // completion monitor
  always @(negedge clk) begin
    if (rst_n && bus.Done_Out === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_done", bus.Done_Out, 0);
      end else begin
        logic [W:0] e;
        e = sb.pop_front();
        check("result", bus.Result_Out, e[W-1:0]);
        check("carry_out", bus.Carry_Out, e[W]);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (bus.Ready_Out !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("ready_timeout", bus.Ready_Out, 1);
  endtask

  // issue one command; returns #1 after the accept edge with Start_In dropped
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      input logic chain, input logic expect_done, input logic [W:0] exp);
    wait_ready();
    bus.Start_In            = 1'b1;
    bus.Operand_A_In        = a;
    bus.Operand_B_In        = b;
    bus.Operation_Select_In = 4'h1;
    bus.Carry_Borrowb_In    = cin;
    bus.Chain_Carry_In      = chain;
    if (expect_done) sb.push_back(exp);
    @(posedge clk);
    #1;
    bus.Start_In = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("sb_drain", sb.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    int lat;
    rst_n                   = 1'b0;
    bus.Start_In            = 1'b0;
    bus.Operand_A_In        = '0;
    bus.Operand_B_In        = '0;
    bus.Operation_Select_In = 4'h0;
    bus.Carry_Borrowb_In    = 1'b0;
    bus.Chain_Carry_In      = 1'b0;
`ifdef ALU_SEQ_ABORT_EN
    bus.Abort_In            = 1'b0;
`endif

    // reset state
    repeat (2) @(negedge clk);
    check("rst_ready", bus.Ready_Out, 1);
    check("rst_done", bus.Done_Out, 0);
    check("rst_result", bus.Result_Out, 16'h0000);
    check("rst_carry", bus.Carry_Out, 0);
    check("rst_alu_reset", bus.Alu_Reset_Out, 1);
    check("rst_alu_op", bus.Alu_Operation_Select_Out, 4'h0);
    rst_n = 1'b1;
    #1;
    check("alu_reset_held", bus.Alu_Reset_Out, 1);
    @(negedge clk);
    check("alu_reset_clear", bus.Alu_Reset_Out, 0);

    // chained add with latency measurement
    send(16'h1111, 16'h0F0F, 1'b0, 1'b1, 1'b1, {1'b0, 16'h2020});
    lat = 0;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.Done_Out === 1'b1) begin
        lat = e;
        break;
      end
    end
    check("done_latency", lat, 4);
    @(negedge clk);
    check("done_one_cycle", bus.Done_Out, 0);
    check("ready_after_done", bus.Ready_Out, 1);
    drain();

    // unchained add
    send(16'h1111, 16'h0F0F, 1'b0, 1'b0, 1'b1, {1'b0, 16'h1010});
    drain();

    // unchained with carry-in on every nibble
    send(16'h0003, 16'h0004, 1'b1, 1'b0, 1'b1, {1'b0, 16'h1118});
    drain();

    // overflow, with per-nibble carry into the ALU
    send(16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b1, {1'b1, 16'h0000});
    @(negedge clk);
    check("ovf_cin_nib0", bus.Alu_Carry_Borrowb_Out, 0);
    check("ovf_a_nib0", bus.Alu_Data_A_Out, 4'hF);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      check("ovf_cin_chain", bus.Alu_Carry_Borrowb_Out, 1);
    end
    drain();

    // Start_In held high: operands change after accept, second command waits for IDLE
    wait_ready();
    bus.Start_In     = 1'b1;
    bus.Operand_A_In = 16'h1234;
    bus.Operand_B_In = 16'h1111;
    bus.Chain_Carry_In   = 1'b1;
    bus.Carry_Borrowb_In = 1'b0;
    sb.push_back({1'b0, 16'h2345});
    @(posedge clk);
    #1;
    bus.Operand_A_In = 16'h8001;
    bus.Operand_B_In = 16'h8000;
    sb.push_back({1'b1, 16'h0001});
    @(negedge clk);
    check("busy_ready_low", bus.Ready_Out, 0);
    wait_ready();
    @(posedge clk);
    #1;
    bus.Start_In = 1'b0;
    drain();
    repeat (6) @(negedge clk);

`ifdef ALU_SEQ_ABORT_EN
    // abort at nibble 1 keeps the previous result
    send(16'h1111, 16'h1111, 1'b0, 1'b1, 1'b0, '0);
    @(posedge clk);
    #1;
    bus.Abort_In = 1'b1;
    @(posedge clk);
    #1;
    bus.Abort_In = 1'b0;
    @(negedge clk);
    check("abort_ready", bus.Ready_Out, 1);
    check("abort_result_kept", bus.Result_Out, 16'h0001);
    check("abort_carry_kept", bus.Carry_Out, 1);
    repeat (6) @(negedge clk);
`endif

    // reset in the middle of nibble 2
    send(16'h2222, 16'h1111, 1'b0, 1'b1, 1'b0, '0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_result", bus.Result_Out, 16'h0000);
    check("midrst_ready", bus.Ready_Out, 1);
    check("midrst_done", bus.Done_Out, 0);
    check("midrst_alu_reset", bus.Alu_Reset_Out, 1);
    check("midrst_alu_a", bus.Alu_Data_A_Out, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_alu_reset_clear", bus.Alu_Reset_Out, 0);
    repeat (8) @(negedge clk);
    check("midrst_idle_ready", bus.Ready_Out, 1);

    // normal operation after reset
    send(16'hA5A5, 16'h0101, 1'b1, 1'b1, 1'b1, {1'b0, 16'hA6A7});
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_4_bit_wide_sequencer.md
Name: alu_4_bit_wide_sequencer

Overview:
Multi-cycle controller that runs wide operands through one shared ALU_4_Bit instance, one nibble per clock, least significant nibble first. It accepts a command with a start/ready handshake, drives the ALU ports, captures each nibble result, and can chain carry/borrow between nibbles. It sits between the control path and the ALU, so a 4-bit datapath can perform 4*NUM_NIBBLES-bit operations.

Parameters:
NUM_NIBBLES, 4, number of 4-bit slices per operand; width W = 4*NUM_NIBBLES; legal range 2..16.

Ports:
Clock_In  input  1  single clock, rising edge.
Resetb_In  input  1  asynchronous, active-low reset.
Start_In  input  1  command valid.
Ready_Out  output  1  high when a command can be accepted.
Operand_A_In  input  W  wide operand A.
Operand_B_In  input  W  wide operand B.
Operation_Select_In  input  4  ALU opcode, passed through unchanged.
Carry_Borrowb_In  input  1  carry/borrow-bar into nibble 0.
Chain_Carry_In  input  1  1 = ripple ALU carry between nibbles; 0 = every nibble uses Carry_Borrowb_In.
Alu_Reset_Out  output  1  drives the ALU's active-high Reset_In.
Alu_Data_A_Out  output  4  current nibble of A to the ALU.
Alu_Data_B_Out  output  4  current nibble of B to the ALU.
Alu_Carry_Borrowb_Out  output  1  carry/borrow-bar to the ALU.
Alu_Operation_Select_Out  output  4  latched opcode to the ALU.
Alu_Result_In  input  4  ALU Result_Out, combinational.
Alu_Carry_In  input  1  ALU Carry_Out, combinational.
Result_Out  output  W  assembled wide result.
Carry_Out  output  1  ALU carry from the last nibble.
Done_Out  output  1  one-cycle completion pulse.

Behaviour:
- Reset (Resetb_In low, asynchronous, also mid-operation):
  - state = IDLE, nibble index = 0.
  - Ready_Out = 1, Done_Out = 0, Result_Out = 0, Carry_Out = 0.
  - All Alu_*_Out = 0 except Alu_Reset_Out = 1.
  - Alu_Reset_Out clears on the first rising edge after Resetb_In rises.
  - A command in flight is discarded.
- States: IDLE, EXEC, DONE.
- IDLE:
  - Ready_Out = 1.
  - Accept on a rising edge with Start_In & Ready_Out: latch operands, opcode, Carry_Borrowb_In and Chain_Carry_In; index <- 0; go to EXEC.
  - Alu data/carry/opcode outputs driven 0.
- EXEC:
  - Ready_Out = 0.
  - ALU outputs come combinationally from the latched registers: nibble k = bits [4k+3:4k] of each operand, plus the latched opcode.
  - Alu_Carry_Borrowb_Out = latched Carry_Borrowb_In when k = 0 or chain = 0; otherwise the carry register.
  - Each edge: result[4k+3:4k] <- Alu_Result_In; carry register <- Alu_Carry_In; k <- k+1.
  - After the edge with k = NUM_NIBBLES-1, go to DONE.
  - Exactly NUM_NIBBLES EXEC cycles.
- DONE (one cycle):
  - Done_Out = 1, Ready_Out = 0.
  - Result_Out and Carry_Out take the new values on entry to DONE and hold until the next DONE entry.
  - Then return to IDLE.
- Latency: accept edge T; Done_Out high in cycle T+NUM_NIBBLES; next accept possible at edge T+NUM_NIBBLES+1.
- Boundary cases:
  - Start_In while Ready_Out = 0 is ignored; no queueing.
  - Operand changes after accept have no effect.
  - Opcode 4'hF and all-zero operands need no special handling.
  - Index never exceeds NUM_NIBBLES-1.

Optional Feature:
ALU_SEQ_ABORT_EN:
- Defined: adds input Abort_In (1 bit). Abort_In = 1 on an edge in EXEC returns the block to IDLE with no Done_Out pulse; Result_Out and Carry_Out keep their previous values. Abort_In is ignored in IDLE and DONE; Abort has priority over the final-nibble transition.
- Undefined: port absent; EXEC always runs to completion.

Test Plan:
Bench setup: NUM_NIBBLES = 4. A bench ALU model returns A+B+Cin on Alu_Result_In and Alu_Carry_In for opcode 4'h1.
- Reset: hold Resetb_In low -> Ready_Out = 1, Done_Out = 0, Result_Out = 16'h0000, Alu_Reset_Out = 1; it clears one edge after release.
- Chained add: A = 16'h1111, B = 16'h0F0F, Cin = 0, chain = 1 -> Result_Out = 16'h2020, Carry_Out = 0, Done_Out high exactly 4 cycles after the accept edge.
- Unchained add: same operands, chain = 0 -> Result_Out = 16'h1010, Carry_Out = 0.
- Overflow: A = 16'hFFFF, B = 16'h0001, chain = 1 -> Result_Out = 16'h0000, Carry_Out = 1; Alu_Carry_Borrowb_Out = 1 on nibbles 1..3.
- Handshake: Start_In held high through EXEC and DONE -> only one command executes; the second is accepted on the first IDLE edge and completes with the new operands.
- Reset and abort:
  - Resetb_In pulsed low at nibble 2 -> Result_Out = 0, Ready_Out = 1, no Done_Out.
  - With ALU_SEQ_ABORT_EN, Abort_In at nibble 1 -> IDLE, previous Result_Out kept, no Done_Out.
